// File: rtl/qram_ctrl_pkg.sv
// Shared types and defaults for the QRAM access controller.
// Holds the controller state enum, the default parameter values and a
// helper that sizes the shared bit counter.
package qram_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W         = 4;
    localparam int unsigned DEF_PULSE_CYC      = 2;
    localparam int unsigned DEF_REFRESH_PERIOD = 64;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR       = 3'd1,
        SETUP      = 3'd2,
        STROBE     = 3'd3,
        RECOVER    = 3'd4,
        REFRESH_RD = 3'd5,
        REFRESH_WR = 3'd6
    } state_t;

    // Counter width: ceil(log2(max(a, b))) + 1
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/qram_access_controller_if.sv
// Request/response and array-side signal bundle of the QRAM controller.
// slave  : controller view (takes requests, drives the array pins)
// master : host/array environment view
// Signals: ReqValid/ReqReady/ReqWrite/ReqAddr/ReqData, RspValid/RspData,
//          AddressQBit/inputQBit/Write/Read/outputQBit, Busy.
interface qram_access_controller_if
    import qram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic [ADDR_W-1:0] ReqAddr;
    logic              ReqData;
    logic              RspValid;
    logic              RspData;
    logic              AddressQBit;
    logic              inputQBit;
    logic              Write;
    logic              Read;
    logic              outputQBit;
    logic              Busy;

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqData, outputQBit,
        output ReqReady, RspValid, RspData, AddressQBit, inputQBit, Write, Read, Busy
    );

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqData, outputQBit,
        input  ReqReady, RspValid, RspData, AddressQBit, inputQBit, Write, Read, Busy
    );
endinterface

// File: rtl/qram_addr_shifter.sv
// Address load/shift register plus saturating down-counter.
// Ports: clk, rst_n (async active-low); i_load loads i_load_addr and
// i_load_cnt; i_shift shifts the address left (MSB first, zero fill) and
// decrements the counter; o_bit is the registered MSB; o_done flags count 0.
module qram_addr_shifter
    import qram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [CNT_W-1:0]  i_load_cnt,
    input  logic              i_shift,
    output logic              o_bit,
    output logic              o_done
);
    logic [ADDR_W-1:0] r_sreg;
    logic [CNT_W-1:0]  r_cnt;

    // Zero fill means the serial output returns to 0 once the address is out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_sreg <= i_load_addr;
            r_cnt  <= i_load_cnt;
        end else if (i_shift) begin
            r_sreg <= r_sreg << 1;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_bit  = r_sreg[ADDR_W-1];
    assign o_done = (r_cnt == '0);
endmodule

// File: rtl/qram_access_controller.sv
// Initiator for the serial-address QRAM array.
// Takes single-bit read/write requests on a valid/ready handshake, shifts
// the address out MSB first on AddressQBit, pulses Write or Read for
// PULSE_CYC cycles and returns read data on a one-cycle RspValid pulse.
// Ports: DDRClockP (clock), ResetN (async active-low), bus (slave modport).
// Build option: define QRAM_REFRESH_EN to enable periodic read-restore
// refresh of every cell (REFRESH_PERIOD cycles between refreshes).
module qram_access_controller
    import qram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned PULSE_CYC      = DEF_PULSE_CYC,
    parameter int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
    input  logic                      DDRClockP,
    input  logic                      ResetN,
    qram_access_controller_if.slave   bus
);
    localparam int unsigned CNT_W = cnt_width(ADDR_W, PULSE_CYC);

    // Reject illegal parameterisations at elaboration
    if (PULSE_CYC == 0 || REFRESH_PERIOD == 0) begin : g_param_check
        $error("qram_access_controller: PULSE_CYC and REFRESH_PERIOD must be >= 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_wr;
    logic              r_data;
    logic              r_refresh;
    logic [ADDR_W-1:0] r_rf_addr;
    logic              w_refresh_due;
    logic              w_accept;
    logic              w_rf_start;
    logic              w_done;
    logic              w_addr_bit;

    logic              w_ld;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [CNT_W-1:0]  w_ld_cnt;
    logic              w_shift;

    logic              w_write_nxt;
    logic              w_read_nxt;
    logic              w_inq_nxt;
    logic              w_rspv_nxt;
    logic              w_busy_nxt;

    logic              r_write;
    logic              r_read;
    logic              r_inq;
    logic              r_rspv;
    logic              r_rsp_data;
    logic              r_busy;

    assign w_accept   = (r_state == IDLE) && !w_refresh_due && bus.ReqValid;
    assign w_rf_start = (r_state == IDLE) && w_refresh_due;

    // State register
    always_ff @(posedge DDRClockP or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a pending refresh wins over a host request in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_refresh_due || bus.ReqValid) begin
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (w_done) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP:  w_state_nxt = STROBE;
            STROBE: begin
                if (w_done) begin
                    if (r_refresh) begin
                        w_state_nxt = r_wr ? REFRESH_WR : REFRESH_RD;
                    end else begin
                        w_state_nxt = RECOVER;
                    end
                end
            end
            RECOVER:    w_state_nxt = IDLE;
            REFRESH_RD: w_state_nxt = ADDR;
            REFRESH_WR: w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs plus shifter control
    always_comb begin
        w_write_nxt = 1'b0;
        w_read_nxt  = 1'b0;
        w_inq_nxt   = 1'b0;
        w_rspv_nxt  = 1'b0;
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_ld        = 1'b0;
        w_ld_addr   = '0;
        w_ld_cnt    = '0;
        w_shift     = 1'b0;

        case (w_state_nxt)
            SETUP:   w_inq_nxt = r_wr & r_data;
            STROBE: begin
                w_inq_nxt   = r_wr & r_data;
                w_write_nxt = r_wr;
                w_read_nxt  = !r_wr;
            end
            RECOVER: w_rspv_nxt = !r_wr;
            default: ;
        endcase

        if (w_accept) begin
            w_ld      = 1'b1;
            w_ld_addr = bus.ReqAddr;
            w_ld_cnt  = CNT_W'(ADDR_W - 1);
        end else if (w_rf_start || (r_state == REFRESH_RD)) begin
            w_ld      = 1'b1;
            w_ld_addr = r_rf_addr;
            w_ld_cnt  = CNT_W'(ADDR_W - 1);
        end else if (r_state == SETUP) begin
            // Reuse the counter for the strobe width; address register stays 0
            w_ld      = 1'b1;
            w_ld_cnt  = CNT_W'(PULSE_CYC - 1);
        end else if ((r_state == ADDR) || (r_state == STROBE)) begin
            w_shift   = 1'b1;
        end
    end

    qram_addr_shifter #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .clk         (DDRClockP),
        .rst_n       (ResetN),
        .i_load      (w_ld),
        .i_load_addr (w_ld_addr),
        .i_load_cnt  (w_ld_cnt),
        .i_shift     (w_shift),
        .o_bit       (w_addr_bit),
        .o_done      (w_done)
    );

    // Operation attributes and read capture
    always_ff @(posedge DDRClockP or negedge ResetN) begin
        if (!ResetN) begin
            r_wr       <= 1'b0;
            r_data     <= 1'b0;
            r_refresh  <= 1'b0;
            r_rsp_data <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr      <= bus.ReqWrite;
                r_data    <= bus.ReqData;
                r_refresh <= 1'b0;
            end else if (w_rf_start) begin
                r_wr      <= 1'b0;
                r_data    <= 1'b0;
                r_refresh <= 1'b1;
            end else if (r_state == REFRESH_RD) begin
                r_wr      <= 1'b1;
            end
            // Sample on the edge that ends the last strobe cycle
            if ((r_state == STROBE) && w_done && !r_wr) begin
                if (r_refresh) begin
                    r_data     <= bus.outputQBit;
                end else begin
                    r_rsp_data <= bus.outputQBit;
                end
            end
        end
    end

    // Registered outputs
    always_ff @(posedge DDRClockP or negedge ResetN) begin
        if (!ResetN) begin
            r_write <= 1'b0;
            r_read  <= 1'b0;
            r_inq   <= 1'b0;
            r_rspv  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_write <= w_write_nxt;
            r_read  <= w_read_nxt;
            r_inq   <= w_inq_nxt;
            r_rspv  <= w_rspv_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

`ifdef QRAM_REFRESH_EN
    localparam int unsigned RF_W = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_PERIOD - 1);

    logic [RF_W-1:0] r_rf_cnt;

    // Period counter saturates at the due value and is frozen while a refresh runs
    always_ff @(posedge DDRClockP or negedge ResetN) begin
        if (!ResetN) begin
            r_rf_cnt  <= '0;
            r_rf_addr <= '0;
        end else begin
            if (w_rf_start) begin
                r_rf_cnt <= '0;
            end else if (!(r_refresh && (r_state != IDLE)) && (r_rf_cnt != RF_LAST)) begin
                r_rf_cnt <= r_rf_cnt + RF_W'(1);
            end
            if (r_state == REFRESH_WR) begin
                r_rf_addr <= r_rf_addr + ADDR_W'(1);
            end
        end
    end

    assign w_refresh_due = (r_rf_cnt == RF_LAST);
`else
    assign w_refresh_due = 1'b0;
    assign r_rf_addr     = '0;
`endif

    assign bus.ReqReady    = (r_state == IDLE) && !w_refresh_due;
    assign bus.RspValid    = r_rspv;
    assign bus.RspData     = r_rsp_data;
    assign bus.AddressQBit = w_addr_bit;
    assign bus.inputQBit   = r_inq;
    assign bus.Write       = r_write;
    assign bus.Read        = r_read;
    assign bus.Busy        = r_busy;
endmodule

// File: tb/tb_qram_access_controller.sv
// Directed bench for qram_access_controller with a behavioural QRAM array.
module tb_qram_access_controller;
    import qram_ctrl_pkg::*;

    localparam int unsigned ADDR_W    = DEF_ADDR_W;
    localparam int unsigned PULSE_CYC = DEF_PULSE_CYC;
`ifdef QRAM_REFRESH_EN
    localparam int unsigned REFRESH_PERIOD = 16;
    localparam logic [9:1]  TAIL_MASK      = 9'b011111111;
`else
    localparam int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD;
    localparam logic [9:1]  TAIL_MASK      = 9'b111111111;
`endif

    logic DDRClockP = 1'b0;
    logic ResetN    = 1'b0;

    qram_access_controller_if #(.ADDR_W(ADDR_W)) bus ();

    qram_access_controller #(
        .ADDR_W         (ADDR_W),
        .PULSE_CYC      (PULSE_CYC),
        .REFRESH_PERIOD (REFRESH_PERIOD)
    ) dut (
        .DDRClockP (DDRClockP),
        .ResetN    (ResetN),
        .bus       (bus)
    );

    always #5 DDRClockP = ~DDRClockP;

    // Behavioural array: cells 0 and 3 hold 1
    logic [15:0] mem       = 16'h0009;
    logic [5:0]  hist      = '0;
    logic        prev_strb = 1'b0;
    logic [3:0]  m_addr    = '0;
    logic [3:0]  last_wr   = '0;
`ifdef QRAM_REFRESH_EN
    logic [3:0]  prev_wr   = '0;
    int          wr_cnt    = 0;
`endif

    // Address is the ADDR_W bits seen before the SETUP cycle preceding the strobe
    always @(negedge DDRClockP) begin
        if ((bus.Read || bus.Write) && !prev_strb) begin
            m_addr = hist[4:1];
            if (bus.Write) begin
                mem[m_addr] = bus.inputQBit;
`ifdef QRAM_REFRESH_EN
                prev_wr = last_wr;
                wr_cnt  = wr_cnt + 1;
`endif
                last_wr = m_addr;
            end
            bus.outputQBit = mem[m_addr];
        end
        prev_strb = bus.Read || bus.Write;
        hist      = {hist[4:0], bus.AddressQBit};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [9:1] t_addr, t_inq, t_wr, t_rd, t_rspv, t_rdy, t_busy, t_rdata;

    // Per-cycle trace of cycles 1..9 after the acceptance edge
    task automatic trace9();
        for (int k = 1; k <= 9; k++) begin
            @(negedge DDRClockP);
            t_addr[k]  = bus.AddressQBit;
            t_inq[k]   = bus.inputQBit;
            t_wr[k]    = bus.Write;
            t_rd[k]    = bus.Read;
            t_rspv[k]  = bus.RspValid;
            t_rdy[k]   = bus.ReqReady;
            t_busy[k]  = bus.Busy;
            t_rdata[k] = bus.RspData;
        end
    endtask

    // Present a request, wait for acceptance, then scramble the request inputs
    task automatic issue(input logic wr, input logic [3:0] addr, input logic d);
        int waited;
        waited = 0;
        @(negedge DDRClockP);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = wr;
        bus.ReqAddr  = addr;
        bus.ReqData  = d;
        while (!bus.ReqReady && waited < 200) begin
            @(negedge DDRClockP);
            waited++;
        end
        if (!bus.ReqReady) check("issue_timeout", 32'(bus.ReqReady), 32'(1));
        @(posedge DDRClockP);
        #1;
        bus.ReqValid = 1'b0;
        bus.ReqWrite = ~wr;
        bus.ReqAddr  = ~addr;
        bus.ReqData  = ~d;
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic exp_bit);
        issue(1'b0, addr, 1'b0);
        trace9();
        check({tag, "_rspv"}, 32'(t_rspv), 32'(9'b010000000));
        check({tag, "_rspdata"}, 32'(t_rdata[8]), 32'(exp_bit));
    endtask

    logic acc;
    int   last_acc, n_acc, bad_gap, both, gap, waited;
    logic seen, rspv_seen;
    int   rdy_low;

    initial begin
        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = '0;
        bus.ReqData  = 1'b0;

        // Reset state
        repeat (3) @(negedge DDRClockP);
        check("reset_outs", 32'({bus.ReqReady, bus.Busy, bus.Write, bus.Read, bus.AddressQBit,
                                 bus.inputQBit, bus.RspValid, bus.RspData}), 32'(8'b1000_0000));
        ResetN = 1'b1;
        @(negedge DDRClockP);
        check("post_reset_idle", 32'({bus.ReqReady, bus.Busy}), 32'(2'b10));

        // Write 1 to 1010; inputs change right after acceptance
        issue(1'b1, 4'b1010, 1'b1);
        trace9();
        check("wr_addr_bits", 32'(t_addr), 32'(9'b000000101));
        check("wr_inq",       32'(t_inq),  32'(9'b001110000));
        check("wr_strobe",    32'(t_wr),   32'(9'b001100000));
        check("wr_no_read",   32'(t_rd),   32'(0));
        check("wr_no_rspv",   32'(t_rspv), 32'(0));
        check("wr_ready",     32'(t_rdy & TAIL_MASK),  32'(9'b100000000 & TAIL_MASK));
        check("wr_busy",      32'(t_busy & TAIL_MASK), 32'(9'b011111111));
        check("wr_cell",      32'(mem[10]), 32'(1));
        check("wr_latched_addr", 32'(last_wr), 32'(10));
        check("cell5_untouched", 32'(mem[5]), 32'(0));

        // Read 0011 (holds 1)
        issue(1'b0, 4'b0011, 1'b0);
        trace9();
        check("rd_addr_bits", 32'(t_addr), 32'(9'b000001100));
        check("rd_strobe",    32'(t_rd),   32'(9'b001100000));
        check("rd_no_write",  32'(t_wr),   32'(0));
        check("rd_inq_zero",  32'(t_inq),  32'(0));
        check("rd_rspv",      32'(t_rspv), 32'(9'b010000000));
        check("rd_rspdata",   32'(t_rdata[8]), 32'(1));

        // Readback of the written cell and of the cell the scrambled inputs named
        read_check("rd1010", 4'b1010, 1'b1);
        read_check("rd0101", 4'b0101, 1'b0);

        // ReqValid held high, alternating read/write
        last_acc = -1; n_acc = 0; bad_gap = 0; both = 0;
        @(negedge DDRClockP);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = 4'b0110;
        bus.ReqData  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge DDRClockP);
            if (bus.Read && bus.Write) both++;
            acc = bus.ReqReady;
            if (acc) begin
                gap = n - last_acc;
`ifdef QRAM_REFRESH_EN
                if (last_acc >= 0 && gap != 9 && gap != 25) bad_gap++;
`else
                if (last_acc >= 0 && gap != 9) bad_gap++;
`endif
                last_acc = n;
                n_acc++;
            end
            @(posedge DDRClockP);
            #1;
            if (acc) begin
                bus.ReqWrite = ~bus.ReqWrite;
                bus.ReqAddr  = bus.ReqAddr + 4'd1;
            end
        end
        bus.ReqValid = 1'b0;
`ifndef QRAM_REFRESH_EN
        check("b2b_accepts", 32'(n_acc), 32'(5));
`endif
        check("b2b_gap",     32'(bad_gap), 32'(0));
        check("rw_overlap",  32'(both),    32'(0));

        // Reset in the middle of a write strobe
        issue(1'b1, 4'b1111, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge DDRClockP);
            seen = bus.Write;
        end
        check("rst_saw_strobe", 32'(seen), 32'(1));
        #2;
        ResetN = 1'b0;
        #1;
        check("rst_async_outs", 32'({bus.Write, bus.Busy, bus.ReqReady, bus.inputQBit, bus.RspValid}),
              32'(5'b00100));
        @(negedge DDRClockP);
        ResetN = 1'b1;
        rspv_seen = 1'b0;
        rdy_low   = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge DDRClockP);
            rspv_seen = rspv_seen | bus.RspValid;
            if (!bus.ReqReady) rdy_low++;
        end
        check("rst_no_rspv",    32'(rspv_seen), 32'(0));
        check("rst_ready_held", 32'(rdy_low),   32'(0));

`ifdef QRAM_REFRESH_EN
        // Request arrives in the RefreshDue cycle: refresh of cell 0 runs first
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge DDRClockP);
            seen = !bus.ReqReady && !bus.Busy;
        end
        check("rf_due_seen", 32'(seen), 32'(1));
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = 4'd5;
        waited = 0;
        do begin
            @(negedge DDRClockP);
            waited++;
        end while (!bus.ReqReady && waited < 100);
        check("rf_accept_delay", 32'(waited), 32'(17));
        check("rf_cell0_addr",   32'(last_wr), 32'(0));
        check("rf_cell0_keep",   32'(mem[0]),  32'(1));
        @(posedge DDRClockP);
        #1;
        bus.ReqValid = 1'b0;

        // Sixteen more refreshes walk addresses 1..15 then wrap to 0
        gap = wr_cnt + 16;
        waited = 0;
        while (wr_cnt < gap && waited < 3000) begin
            @(negedge DDRClockP);
            waited++;
        end
        check("rf_wrap_count", 32'(wr_cnt), 32'(gap));
        check("rf_wrap",       32'({prev_wr, last_wr}), 32'({4'd15, 4'd0}));
        check("rf_cell0_final", 32'(mem[0]), 32'(1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
